// File: rtl/pc104_pkg.sv
// Shared definitions for the PC104 time-sync initiator: responder register map,
// field limits, sequencer state encoding and the set-request range check.
package pc104_pkg;

  localparam logic [1:0] OFF_SEC  = 2'd0;
  localparam logic [1:0] OFF_MIN  = 2'd1;
  localparam logic [1:0] OFF_HR   = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  localparam logic [7:0] CTRL_LOAD = 8'h01;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] SEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_STEP   = 3'd4
  } state_t;

  function automatic logic fields_ok(input logic [4:0] hr, input logic [5:0] mn,
                                     input logic [5:0] sc);
    return (hr <= HR_MAX) && (mn <= MIN_MAX) && (sc <= SEC_MAX);
  endfunction

endpackage

// File: rtl/pc104_sync_master_if.sv
// ISA-style I/O bus between the PC104 initiator (master) and the time-sync responder (slave).
interface pc104_sync_master_if;
  logic       write_n;
  logic       read_n;
  logic [9:0] address;
  logic       aen;
  logic [7:0] data_bus_out;
  logic       data_oe;
  logic [7:0] data_bus_in;

  modport master (
    output write_n, read_n, address, aen, data_bus_out, data_oe,
    input  data_bus_in
  );

  modport slave (
    input  write_n, read_n, address, aen, data_bus_out, data_oe,
    output data_bus_in
  );
endinterface

// File: rtl/pc104_io_cycle.sv
// Single I/O access engine: SETUP/STROBE/HOLD timing, strobe and data_oe generation,
// read capture. STEP is a one-cycle gap in which the sequencer may chain the next access.
module pc104_io_cycle
  import pc104_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR     = 10'h300,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       is_write,
  input  logic [1:0] offset,
  input  logic [7:0] wdata,
  output state_t     state,
  output logic [5:0] rdata,
  pc104_sync_master_if.master bus
);

  localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

  state_t     state_r, state_nxt;
  logic [2:0] cnt_r, cnt_nxt;
  logic       wr_r, wr_nxt;
  logic [1:0] off_r, off_nxt;
  logic [7:0] wdata_r, wdata_nxt;
  logic [5:0] rdata_r;
  logic       in_cycle_s;

  // Next-state and access-latch logic
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    wr_nxt    = wr_r;
    off_nxt   = off_r;
    wdata_nxt = wdata_r;
    case (state_r)
      ST_IDLE, ST_STEP: begin
        if (start) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = 3'd0;
          wr_nxt    = is_write;
          off_nxt   = offset;
          wdata_nxt = wdata;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_r + 3'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_r + 3'd1;
        end
      end
      ST_HOLD: state_nxt = ST_STEP;
      default: state_nxt = ST_IDLE;
    endcase
    in_cycle_s = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);
  end

  // State register; bus outputs are registered from the next state so they are glitch-free
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 3'd0;
      wr_r             <= 1'b0;
      off_r            <= 2'd0;
      wdata_r          <= 8'd0;
      rdata_r          <= 6'd0;
      bus.write_n      <= 1'b1;
      bus.read_n       <= 1'b1;
      bus.aen          <= 1'b1;
      bus.address      <= 10'd0;
      bus.data_oe      <= 1'b0;
      bus.data_bus_out <= 8'd0;
    end else begin
      state_r          <= state_nxt;
      cnt_r            <= cnt_nxt;
      wr_r             <= wr_nxt;
      off_r            <= off_nxt;
      wdata_r          <= wdata_nxt;
      bus.aen          <= !in_cycle_s;
      bus.address      <= in_cycle_s ? (BASE_ADDR + {8'd0, off_nxt}) : 10'd0;
      bus.read_n       <= !((state_nxt == ST_STROBE) && !wr_nxt);
      bus.write_n      <= !((state_nxt == ST_STROBE) && wr_nxt);
      bus.data_oe      <= in_cycle_s && wr_nxt;
      bus.data_bus_out <= (in_cycle_s && wr_nxt) ? wdata_nxt : 8'd0;
      // Only the low six bits ever carry a time field
      if ((state_r == ST_STROBE) && (cnt_r == STROBE_LAST) && !wr_r) begin
        rdata_r <= bus.data_bus_in[5:0];
      end
    end
  end

  assign state = state_r;
  assign rdata = rdata_r;

endmodule

// File: rtl/pc104_sync_master.sv
// PC104 time-sync initiator: reads hr/min/sec on each responder irq edge and writes
// hr/min/sec plus a load command on a local set request.
module pc104_sync_master
  import pc104_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR     = 10'h300,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       irq_in,
  input  logic       set_valid,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_ready,
  output logic       set_err,
  output logic       wr_done,
  output logic       rd_done,
  output logic [4:0] rd_hr,
  output logic [5:0] rd_min,
  output logic [5:0] rd_sec,
  output logic       busy,
  pc104_sync_master_if.master bus
);

  logic [2:0] irq_sync_r;
  logic       irq_edge_s;
  state_t     io_state_s;
  logic [5:0] rdata_s;
  logic       idle_s, hold_s, step_s, last_s, ok_s, set_ready_s;
  logic       start_wr_s, start_rd_s, next_access_s, start_s, op_wr_s;
  logic [1:0] op_idx_s, op_off_s;
  logic [7:0] op_data_s;

  logic       mode_wr_r, rd_pending_r;
  logic [1:0] idx_r;
  logic [4:0] hr_r, cap_hr_r, rd_hr_r;
  logic [5:0] min_r, sec_r, cap_min_r, rd_min_r, rd_sec_r;
  logic       set_err_r, wr_done_r, rd_done_r;

  assign irq_edge_s    = irq_sync_r[1] && !irq_sync_r[2];
  assign idle_s        = (io_state_s == ST_IDLE);
  assign hold_s        = (io_state_s == ST_HOLD);
  assign step_s        = (io_state_s == ST_STEP);
  assign last_s        = mode_wr_r ? (idx_r == 2'd3) : (idx_r == 2'd2);
  assign ok_s          = fields_ok(set_hr, set_min, set_sec);
  assign set_ready_s   = idle_s && !rd_pending_r;
  assign start_wr_s    = set_ready_s && set_valid && ok_s;
  assign start_rd_s    = idle_s && !start_wr_s && (irq_edge_s || rd_pending_r);
  assign next_access_s = step_s && !last_s;
  assign start_s       = start_wr_s || start_rd_s || next_access_s;
  assign op_wr_s       = idle_s ? start_wr_s : mode_wr_r;
  assign op_idx_s      = idle_s ? 2'd0 : (idx_r + 2'd1);

  // Register offset and write data for the access about to be launched
  always_comb begin
    op_off_s  = OFF_SEC;
    op_data_s = 8'd0;
    if (op_wr_s) begin
      case (op_idx_s)
        2'd0:    begin op_off_s = OFF_SEC; op_data_s = {2'b00, (idle_s ? set_sec : sec_r)}; end
        2'd1:    begin op_off_s = OFF_MIN; op_data_s = {2'b00, min_r}; end
        2'd2:    begin op_off_s = OFF_HR;  op_data_s = {3'b000, hr_r}; end
        default: begin op_off_s = OFF_CTRL; op_data_s = CTRL_LOAD; end
      endcase
    end else begin
      case (op_idx_s)
        2'd0:    op_off_s = OFF_HR;
        2'd1:    op_off_s = OFF_MIN;
        default: op_off_s = OFF_SEC;
      endcase
    end
  end

  pc104_io_cycle #(
    .BASE_ADDR    (BASE_ADDR),
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_io (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_s),
    .is_write(op_wr_s),
    .offset  (op_off_s),
    .wdata   (op_data_s),
    .state   (io_state_s),
    .rdata   (rdata_s),
    .bus     (bus)
  );

  // Sequencer: irq synchroniser, request latching, pending read, access index and results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_sync_r   <= 3'd0;
      mode_wr_r    <= 1'b0;
      idx_r        <= 2'd0;
      rd_pending_r <= 1'b0;
      hr_r         <= 5'd0;
      min_r        <= 6'd0;
      sec_r        <= 6'd0;
      cap_hr_r     <= 5'd0;
      cap_min_r    <= 6'd0;
      rd_hr_r      <= 5'd0;
      rd_min_r     <= 6'd0;
      rd_sec_r     <= 6'd0;
      set_err_r    <= 1'b0;
      wr_done_r    <= 1'b0;
      rd_done_r    <= 1'b0;
    end else begin
      irq_sync_r <= {irq_sync_r[1:0], irq_in};
      if (start_wr_s) begin
        mode_wr_r <= 1'b1;
        idx_r     <= 2'd0;
        hr_r      <= set_hr;
        min_r     <= set_min;
        sec_r     <= set_sec;
      end else if (start_rd_s) begin
        mode_wr_r <= 1'b0;
        idx_r     <= 2'd0;
      end else if (next_access_s) begin
        idx_r <= idx_r + 2'd1;
      end
      // Further edges while a read is already owed simply coalesce
      if (start_rd_s) begin
        rd_pending_r <= 1'b0;
      end else if (irq_edge_s) begin
        rd_pending_r <= 1'b1;
      end
      set_err_r <= set_ready_s && set_valid && !ok_s;
      wr_done_r <= hold_s && last_s && mode_wr_r;
      rd_done_r <= hold_s && last_s && !mode_wr_r;
      if (hold_s && !mode_wr_r) begin
        case (idx_r)
          2'd0:    cap_hr_r  <= rdata_s[4:0];
          2'd1:    cap_min_r <= rdata_s;
          default: begin
            rd_hr_r  <= cap_hr_r;
            rd_min_r <= cap_min_r;
            rd_sec_r <= rdata_s;
          end
        endcase
      end
    end
  end

  assign set_ready = set_ready_s;
  assign busy      = !idle_s;
  assign set_err   = set_err_r;
  assign wr_done   = wr_done_r;
  assign rd_done   = rd_done_r;
  assign rd_hr     = rd_hr_r;
  assign rd_min    = rd_min_r;
  assign rd_sec    = rd_sec_r;

endmodule

// File: tb/tb_pc104_sync_master.sv
// Directed bench for pc104_sync_master: default-timing instance plus a SETUP=3/STROBE=4
// instance, with a small responder model returning per-register read data.
module tb_pc104_sync_master;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq_in, set_valid, set_valid_b;
  logic [4:0] set_hr, set_hr_b;
  logic [5:0] set_min, set_sec, set_min_b, set_sec_b;
  logic       set_ready, set_err, wr_done, rd_done, busy;
  logic [4:0] rd_hr;
  logic [5:0] rd_min, rd_sec;
  logic       set_ready_b, set_err_b, wr_done_b, rd_done_b, busy_b;
  logic [4:0] rd_hr_b;
  logic [5:0] rd_min_b, rd_sec_b;
  logic [7:0] resp_hr, resp_min, resp_sec;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  pc104_sync_master_if bus ();
  pc104_sync_master_if bus_b ();

  // Responder model: data appears only while read_n is low
  always_comb begin
    bus.data_bus_in = 8'hFF;
    if (!bus.read_n) begin
      case (bus.address[1:0])
        2'd2:    bus.data_bus_in = resp_hr;
        2'd1:    bus.data_bus_in = resp_min;
        2'd0:    bus.data_bus_in = resp_sec;
        default: bus.data_bus_in = 8'hFF;
      endcase
    end
  end
  assign bus_b.data_bus_in = 8'h00;

  pc104_sync_master dut (
    .clock(clock), .reset_n(reset_n), .irq_in(irq_in), .set_valid(set_valid),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_ready(set_ready),
    .set_err(set_err), .wr_done(wr_done), .rd_done(rd_done), .rd_hr(rd_hr),
    .rd_min(rd_min), .rd_sec(rd_sec), .busy(busy), .bus(bus)
  );

  pc104_sync_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .irq_in(1'b0), .set_valid(set_valid_b),
    .set_hr(set_hr_b), .set_min(set_min_b), .set_sec(set_sec_b), .set_ready(set_ready_b),
    .set_err(set_err_b), .wr_done(wr_done_b), .rd_done(rd_done_b), .rd_hr(rd_hr_b),
    .rd_min(rd_min_b), .rd_sec(rd_sec_b), .busy(busy_b), .bus(bus_b)
  );

  task automatic test_reset();
    irq_in = 1'b0; set_valid = 1'b0; set_hr = 5'd0; set_min = 6'd0; set_sec = 6'd0;
    set_valid_b = 1'b0; set_hr_b = 5'd0; set_min_b = 6'd0; set_sec_b = 6'd0;
    resp_hr = 8'h00; resp_min = 8'h00; resp_sec = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.write_n, bus.read_n, bus.aen, bus.data_oe, busy, set_ready, set_err, wr_done, rd_done} !== 9'b111001000) begin
      errors++; $display("FAIL reset_ctrl got %b want 111001000",
        {bus.write_n, bus.read_n, bus.aen, bus.data_oe, busy, set_ready, set_err, wr_done, rd_done});
    end
    checks++;
    if ({bus.address, bus.data_bus_out} !== 18'd0) begin
      errors++; $display("FAIL reset_bus got %h/%h want 000/00", bus.address, bus.data_bus_out);
    end
    checks++;
    if ({rd_hr, rd_min, rd_sec} !== 17'd0) begin
      errors++; $display("FAIL reset_rd got %0d/%0d/%0d want 0/0/0", rd_hr, rd_min, rd_sec);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, set_ready, bus.aen} !== 3'b011) begin
      errors++; $display("FAIL reset_release got %b want 011", {busy, set_ready, bus.aen});
    end
  endtask

  task automatic test_write();
    logic [9:0] exp_a [4] = '{10'h300, 10'h301, 10'h302, 10'h303};
    logic [7:0] exp_d [4] = '{8'h38, 8'h22, 8'h0C, 8'h01};
    logic [9:0] got_a [4];
    logic [7:0] got_d [4];
    logic       prev_wn = 1'b1;
    int nw = 0, low = 0, wd_at = 0, wd_cnt = 0, oe_bad = 0;
    @(negedge clock);
    set_hr = 5'd12; set_min = 6'd34; set_sec = 6'd56; set_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 1) set_valid = 1'b0;
      if (!bus.write_n) begin
        if (prev_wn) begin
          if (nw < 4) begin got_a[nw] = bus.address; got_d[nw] = bus.data_bus_out; end
          nw++;
        end
        if (!bus.data_oe) oe_bad++;
        low++;
      end else if (!prev_wn) begin
        checks++;
        if (low !== 2) begin errors++; $display("FAIL wr_strobe_width got %0d want 2", low); end
        low = 0;
      end
      prev_wn = bus.write_n;
      if (wr_done) begin wd_cnt++; if (wd_at == 0) wd_at = k; end
    end
    checks++;
    if (nw !== 4) begin errors++; $display("FAIL wr_count got %0d want 4", nw); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({got_a[i], got_d[i]} !== {exp_a[i], exp_d[i]}) begin
        errors++; $display("FAIL wr_access%0d got %h=%h want %h=%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (oe_bad !== 0) begin errors++; $display("FAIL wr_data_oe got %0d low-oe strobes want 0", oe_bad); end
    checks++;
    if (wd_at !== 20) begin errors++; $display("FAIL wr_done_latency got %0d want 20", wd_at); end
    checks++;
    if (wd_cnt !== 1) begin errors++; $display("FAIL wr_done_count got %0d want 1", wd_cnt); end
  endtask

  task automatic test_read();
    logic       prev_rn = 1'b1, prev_wn = 1'b1;
    logic [16:0] pre = 17'h1FFFF, post = 17'h1FFFF;
    int busy_at = 0, rd_at = 0, rfalls = 0, wfalls = 0;
    resp_hr = 8'hE9; resp_min = 8'h3B; resp_sec = 8'h3B;
    @(negedge clock);
    irq_in = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (busy && busy_at == 0) busy_at = k;
      if (rd_done && rd_at == 0) begin rd_at = k; post = {rd_hr, rd_min, rd_sec}; end
      if (k == 16) pre = {rd_hr, rd_min, rd_sec};
      if (!bus.read_n && prev_rn) rfalls++;
      if (!bus.write_n && prev_wn) wfalls++;
      prev_rn = bus.read_n; prev_wn = bus.write_n;
    end
    checks++;
    if (busy_at !== 3) begin errors++; $display("FAIL irq_sync_latency got %0d want 3", busy_at); end
    checks++;
    if (rd_at !== 17) begin errors++; $display("FAIL rd_done_latency got %0d want 17", rd_at); end
    checks++;
    if (pre !== 17'd0) begin errors++; $display("FAIL rd_early_update got %h want 00000", pre); end
    checks++;
    if (post !== {5'd9, 6'd59, 6'd59}) begin
      errors++; $display("FAIL rd_values got %0d/%0d/%0d want 9/59/59", post[16:12], post[11:6], post[5:0]);
    end
    checks++;
    if ({rfalls, wfalls} !== {32'd3, 32'd0}) begin
      errors++; $display("FAIL rd_strobes got %0d reads %0d writes want 3/0", rfalls, wfalls);
    end
  endtask

  task automatic test_set_err();
    logic [16:0] vec [3] = '{{5'd10, 6'd60, 6'd30}, {5'd24, 6'd0, 6'd0}, {5'd0, 6'd0, 6'd60}};
    int err_at, err_cnt, act;
    for (int v = 0; v < 3; v++) begin
      err_at = 0; err_cnt = 0; act = 0;
      @(negedge clock);
      {set_hr, set_min, set_sec} = vec[v]; set_valid = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clock);
        if (k == 1) set_valid = 1'b0;
        if (set_err) begin err_cnt++; if (err_at == 0) err_at = k; end
        if (!bus.aen || !bus.read_n || !bus.write_n || bus.data_oe || busy) act++;
      end
      checks++;
      if ({err_at, err_cnt} !== {32'd1, 32'd1}) begin
        errors++; $display("FAIL set_err_pulse%0d got at %0d count %0d want 1/1", v, err_at, err_cnt);
      end
      checks++;
      if (act !== 0) begin errors++; $display("FAIL set_err_quiet%0d got %0d busy cycles want 0", v, act); end
    end
    checks++;
    if ({rd_hr, rd_min, rd_sec} !== {5'd9, 6'd59, 6'd59}) begin
      errors++; $display("FAIL set_err_rd_kept got %0d/%0d/%0d want 9/59/59", rd_hr, rd_min, rd_sec);
    end
  endtask

  task automatic test_pending();
    logic       prev_rn = 1'b1, prev_wn = 1'b1, sr_after = 1'b0;
    logic [16:0] post = 17'h1FFFF;
    int busy_at = 0, wd_at = 0, wd_cnt = 0, rd_at = 0, rd_cnt = 0;
    int rfalls = 0, wfalls = 0, first_rd = 0, sr_bad = 0;
    resp_hr = 8'h17; resp_min = 8'hEA; resp_sec = 8'h81;
    irq_in = 1'b0;
    repeat (4) @(negedge clock);
    irq_in = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (busy && busy_at == 0) busy_at = k;
      if (wr_done) begin wd_cnt++; if (wd_at == 0) wd_at = k; end
      if (rd_done) begin rd_cnt++; if (rd_at == 0) begin rd_at = k; post = {rd_hr, rd_min, rd_sec}; end end
      if (!bus.read_n && prev_rn) begin rfalls++; if (first_rd == 0) first_rd = k; end
      if (!bus.write_n && prev_wn) wfalls++;
      prev_rn = bus.read_n; prev_wn = bus.write_n;
      if (k >= 3 && k <= 38 && set_ready) sr_bad++;
      if (k == 40) sr_after = set_ready;
      if (k == 2) begin set_hr = 5'd23; set_min = 6'd59; set_sec = 6'd59; set_valid = 1'b1; end
      if (k == 3) set_valid = 1'b0;
      case (k)
        4, 8, 12, 16: irq_in = 1'b0;
        6, 10, 14:    irq_in = 1'b1;
        default:      ;
      endcase
    end
    checks++;
    if (busy_at !== 3) begin errors++; $display("FAIL pend_start got %0d want 3", busy_at); end
    checks++;
    if ({wd_at, wd_cnt} !== {32'd22, 32'd1}) begin
      errors++; $display("FAIL pend_wr_done got at %0d count %0d want 22/1", wd_at, wd_cnt);
    end
    checks++;
    if ({rd_at, rd_cnt} !== {32'd38, 32'd1}) begin
      errors++; $display("FAIL pend_rd_done got at %0d count %0d want 38/1", rd_at, rd_cnt);
    end
    checks++;
    if ({wfalls, rfalls} !== {32'd4, 32'd3}) begin
      errors++; $display("FAIL pend_strobes got %0d writes %0d reads want 4/3", wfalls, rfalls);
    end
    checks++;
    if (first_rd <= wd_at) begin errors++; $display("FAIL pend_order got first read %0d want after %0d", first_rd, wd_at); end
    checks++;
    if (sr_bad !== 0) begin errors++; $display("FAIL pend_set_ready got %0d high cycles want 0", sr_bad); end
    checks++;
    if (sr_after !== 1'b1) begin errors++; $display("FAIL pend_ready_after got %b want 1", sr_after); end
    checks++;
    if (post !== {5'd23, 6'd42, 6'd1}) begin
      errors++; $display("FAIL pend_rd_values got %0d/%0d/%0d want 23/42/1", post[16:12], post[11:6], post[5:0]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic found = 1'b0;
    int wd_cnt = 0, busy_cnt = 0;
    @(negedge clock);
    set_hr = 5'd12; set_min = 6'd34; set_sec = 6'd56; set_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) set_valid = 1'b0;
      if (!bus.write_n) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL rst_mid_strobe got %b want 1", found); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.write_n, bus.aen, bus.data_oe, bus.read_n, busy} !== 5'b11010) begin
      errors++; $display("FAIL rst_mid_async got %b want 11010", {bus.write_n, bus.aen, bus.data_oe, bus.read_n, busy});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (set_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", set_ready); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (wr_done) wd_cnt++;
      if (busy) busy_cnt++;
    end
    checks++;
    if ({wd_cnt, busy_cnt} !== 64'd0) begin
      errors++; $display("FAIL rst_mid_no_done got %0d done %0d busy want 0/0", wd_cnt, busy_cnt);
    end
  endtask

  task automatic test_params();
    logic       prev_wn = 1'b1;
    logic [9:0] setup_addr = 10'd0, last_a = 10'd0;
    logic [7:0] last_d = 8'd0;
    int setup = 0, low = 0, falls = 0, wd_at = 0;
    @(negedge clock);
    set_hr_b = 5'd1; set_min_b = 6'd2; set_sec_b = 6'd3; set_valid_b = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (k == 1) set_valid_b = 1'b0;
      if (!bus_b.write_n) begin
        if (prev_wn) begin
          falls++;
          last_a = bus_b.address; last_d = bus_b.data_bus_out;
          checks++;
          if (setup < 3 || bus_b.address !== setup_addr) begin
            errors++; $display("FAIL p_setup got %0d stable cycles want >=3", setup);
          end
        end
        low++;
      end else begin
        if (!prev_wn) begin
          checks++;
          if (low !== 4) begin errors++; $display("FAIL p_strobe_width got %0d want 4", low); end
          low = 0;
        end
        if (!bus_b.aen) begin
          setup = (setup > 0 && bus_b.address == setup_addr) ? setup + 1 : 1;
          setup_addr = bus_b.address;
        end else begin
          setup = 0;
        end
      end
      prev_wn = bus_b.write_n;
      if (wr_done_b && wd_at == 0) wd_at = k;
    end
    checks++;
    if (falls !== 4) begin errors++; $display("FAIL p_count got %0d want 4", falls); end
    checks++;
    if ({last_a, last_d} !== {10'h303, 8'h01}) begin
      errors++; $display("FAIL p_ctrl_write got %h=%h want 303=01", last_a, last_d);
    end
    checks++;
    if (wd_at !== 36) begin errors++; $display("FAIL p_wr_done_latency got %0d want 36", wd_at); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_set_err();
    test_pending();
    test_reset_mid_write();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc104_sync_master.md
Name: pc104_sync_master

Overview:
- PC104 bus initiator. It drives the ISA-style I/O cycles that the clock FPGA's PC104 time-sync responder answers.
- On a rising edge of the responder's irq11 it reads back hr/min/sec. On a local set request it writes hr/min/sec and a commit command.
- Used as the host-side engine in the companion controller FPGA, and as the bus model in system benches.

Parameters:
- BASE_ADDR, 10'h300, I/O base of the responder. Register map: +0 sec, +1 min, +2 hr, +3 control (write 8'h01 = load).
- SETUP_CYCLES, 1, clocks the address is valid with aen low before the strobe (range 1..7).
- STROBE_CYCLES, 2, clocks read_n/write_n are held low (range 1..7).

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  1  responder interrupt (irq11). Asynchronous to clock.
- set_valid  in  1  request to write set_hr/set_min/set_sec.
- set_hr  in  5  hours to write, 0..23.
- set_min  in  6  minutes to write, 0..59.
- set_sec  in  6  seconds to write, 0..59.
- set_ready  out  1  high when a set_valid in the same cycle will be accepted.
- set_err  out  1  one-cycle pulse: set request rejected because a field is out of range.
- wr_done  out  1  one-cycle pulse: write sequence finished.
- rd_done  out  1  one-cycle pulse: read sequence finished; rd_hr/rd_min/rd_sec are valid.
- rd_hr  out  5  last hours read.
- rd_min  out  6  last minutes read.
- rd_sec  out  6  last seconds read.
- busy  out  1  high while a bus sequence is in progress.
- write_n  out  1  I/O write strobe, active low.
- read_n  out  1  I/O read strobe, active low.
- address  out  10  I/O address.
- aen  out  1  address enable. Low marks a valid I/O cycle.
- data_bus_out  out  8  write data.
- data_oe  out  1  high while data_bus_out must be driven onto the bus.
- data_bus_in  in  8  read data from the bus.

Behaviour:
- Reset values (asynchronous, take effect immediately, also mid-cycle):
  - write_n=1, read_n=1, aen=1, address=0, data_bus_out=0, data_oe=0.
  - rd_*=0, all pulses=0, busy=0, set_ready=1.
  - Pending flags cleared; FSM to IDLE.
- irq_in handling: passes through a 2-flop synchroniser, then a rising-edge detector. The edge is visible in IDLE 3 clocks after irq_in rises.
- Request acceptance:
  - A set_valid accepted in IDLE with all fields in range latches the fields.
  - If hr>23, min>59 or sec>59: set_err pulses the next cycle and no bus activity occurs.
  - set_ready = IDLE && !rd_pending.
- Pending reads: an irq edge seen while busy sets rd_pending (one deep; further edges coalesce).
- Simultaneous set_valid and irq edge in IDLE: the write runs first, rd_pending is set, and the read starts immediately after wr_done.
- FSM states: IDLE, SETUP, STROBE, HOLD, STEP.
  - SETUP: address=BASE_ADDR+offset, aen=0; lasts SETUP_CYCLES.
  - STROBE: read_n or write_n low; lasts STROBE_CYCLES. data_bus_in is sampled in the last STROBE cycle.
  - HOLD: 1 cycle, strobes high, address and aen held.
  - STEP: advances the access index. The next access re-enters SETUP the following cycle; after the final access it returns to IDLE and pulses done.
- Access sequences:
  - Read sequence: offsets 2, 1, 0 (hr, min, sec).
  - Write sequence: offsets 0, 1, 2, 3. Data is zero-extended {2'b0,sec}, {2'b0,min}, {3'b0,hr}, then 8'h01 to control.
- Write data drive: data_oe=1 and data_bus_out valid from SETUP through HOLD of every write access; otherwise data_oe=0 and data_bus_out=0.
- Read data capture: rd_hr, rd_min and rd_sec update together in the rd_done cycle, from captured data_bus_in[4:0]/[5:0]. Upper bits are ignored. No range check on reads.
- Latency: each access takes SETUP_CYCLES+STROBE_CYCLES+2 clocks. With defaults, rd_done comes 15 clocks after the accept cycle and wr_done 20 clocks after.
- Idle bus state: aen returns to 1 and address to 0 in IDLE. busy=1 from the first SETUP through the done cycle.

Decomposition:
- Shared package pc104_pkg:
  - Register offsets OFF_SEC/OFF_MIN/OFF_HR/OFF_CTRL.
  - CTRL_LOAD=8'h01.
  - HR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - FSM state enum.
- Sub-module pc104_io_cycle: a single-access engine (SETUP/STROBE/HOLD timing, strobe and data_oe generation, read capture). The sequencer above it handles requests, pending state and the access order.

Test Plan:
- Reset mid-STROBE of a write → write_n=1, aen=1, data_oe=0 before the next clock edge; no wr_done; set_ready=1 after reset release.
- set_valid with hr=12, min=34, sec=56 → write cycles to 10'h300=8'h38, 10'h301=8'h22, 10'h302=8'h0C, 10'h303=8'h01, in that order; strobe 2 clocks wide; wr_done 20 clocks after acceptance.
- irq_in rise, responder returns 8'hE9/8'h3B/8'h3B on offsets 2/1/0 → rd_hr=9, rd_min=59, rd_sec=59 (upper bits masked); rd_done 15 clocks after the synchronised edge.
- set_valid with min=60 → set_err pulse; no strobe or aen activity for 30 cycles; rd_* unchanged.
- Irq edge plus set_valid in the same IDLE cycle, then 3 more irq edges during the write → write sequence, then exactly one read sequence; set_ready=0 until rd_done.
- SETUP_CYCLES=3, STROBE_CYCLES=4 → address stable ≥3 clocks before the strobe falls; strobe low exactly 4 clocks; wr_done 36 clocks after acceptance.
